game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/breakout_pkg.sv | 20 ++
 rtl/tick_divider.sv | 22 ++
 rtl/game_sequencer.sv | 120 ++++++++++++
 tb/tb_game_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared types and constants for the breakout game blocks.
package breakout_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_MISS  = 3'd3,
      ST_WIN   = 3'd4,
      ST_OVER  = 3'd5
   } state_t;

   localparam int         NUM_BRICKS = 12;
   localparam logic [3:0] NO_BRICK   = 4'b1111;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks.
module tick_divider #(
   parameter int TICK_DIV = 833333
) (
   input  logic clk,
   input  logic resetn,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)   cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/game_sequencer.sv
// Breakout game sequencer: serve/play/miss flow, lives, score and brick clears.
module game_sequencer
   import breakout_pkg::*;
#(
   parameter int TICK_DIV   = 833333,
   parameter int SERVE_WAIT = 60,
   parameter int LIVES      = 3
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [9:0]            ball_y,
   input  logic                  hit_valid,
   input  logic [3:0]            hit_brick,
   input  logic [NUM_BRICKS-1:0] brick_status,
   output logic                  ball_en,
   output logic                  ball_load,
   output logic [NUM_BRICKS-1:0] brick_clr,
   output logic                  brick_init,
   output logic [1:0]            lives,
   output logic [7:0]            score,
   output logic [2:0]            state,
   output logic                  game_over,
   output logic                  game_won
);

   localparam int SW = (SERVE_WAIT > 1) ? $clog2(SERVE_WAIT) : 1;

   logic          tick;
   logic          start_q, start_armed, start_edge;
   state_t        st, st_n;
   logic [1:0]    lives_n;
   logic [7:0]    score_n;
   logic [SW-1:0] serve_cnt, serve_n;
   logic [NUM_BRICKS-1:0] hit_mask;
   logic          hit_ok;

   tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .resetn (resetn),
      .tick   (tick)
   );

   // A start held through reset must be released before it counts again.
   assign start_edge = start & ~start_q & start_armed;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         start_q     <= 1'b0;
         start_armed <= 1'b0;
         st          <= ST_IDLE;
         lives       <= 2'(LIVES);
         score       <= '0;
         serve_cnt   <= '0;
      end else begin
         start_q     <= start;
         start_armed <= start_armed | ~start;
         st          <= st_n;
         lives       <= lives_n;
         score       <= score_n;
         serve_cnt   <= serve_n;
      end
   end

   // Out-of-range indices shift the bit off the end, so they never match.
   assign hit_mask = NUM_BRICKS'(1) << hit_brick;
   assign hit_ok   = hit_valid && (st == ST_PLAY) && |(hit_mask & brick_status);

   always_comb begin
      st_n       = st;
      lives_n    = lives;
      score_n    = score;
      serve_n    = serve_cnt;
      brick_clr  = '0;
      brick_init = 1'b0;
      case (st)
         ST_IDLE, ST_WIN, ST_OVER: begin
            if (start_edge) begin
               st_n       = ST_SERVE;
               brick_init = 1'b1;
               lives_n    = 2'(LIVES);
               score_n    = '0;
               serve_n    = '0;
            end
         end
         ST_SERVE: begin
            if (tick) begin
               if (serve_cnt == SW'(SERVE_WAIT - 1)) st_n = ST_PLAY;
               else                                  serve_n = serve_cnt + 1'b1;
            end
         end
         ST_PLAY: begin
            if (hit_ok) begin
               brick_clr = hit_mask;
               score_n   = sat_inc8(score);
            end
            if (brick_status == '0)            st_n = ST_WIN;
            else if (tick && (ball_y == '0))   st_n = ST_MISS;
         end
         ST_MISS: begin
            serve_n = '0;
            if (lives <= 2'd1) begin
               lives_n = 2'd0;
               st_n    = ST_OVER;
            end else begin
               lives_n = lives - 2'd1;
               st_n    = ST_SERVE;
            end
         end
         default: st_n = ST_IDLE;
      endcase
   end

   assign ball_en   = tick && (st == ST_PLAY);
   assign ball_load = (st == ST_SERVE);
   assign state     = st;
   assign game_over = (st == ST_OVER);
   assign game_won  = (st == ST_WIN);

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized and directed bench for game_sequencer against a behavioural game model.
`timescale 1ns/1ps
module tb_game_sequencer;
   import breakout_pkg::*;

   localparam int TD = 4;
   localparam int SWAIT = 2;
   localparam int LV = 3;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  ball_y = 10'd100;
   logic        hit_valid = 1'b0;
   logic [3:0]  hit_brick = NO_BRICK;
   logic [11:0] brick_status;
   logic        ball_en, ball_load, brick_init, game_over, game_won;
   logic [11:0] brick_clr;
   logic [1:0]  lives;
   logic [7:0]  score;
   logic [2:0]  state;

   int n_cmp = 0;
   int n_err = 0;
   int n_init = 0;

   // Brick-store environment, driven from the model's view of clears.
   logic [11:0] bricks = 12'hFFF;
   logic        force_empty = 1'b0;
   assign brick_status = force_empty ? 12'h000 : bricks;

   always #5 clk = ~clk;

   game_sequencer #(.TICK_DIV(TD), .SERVE_WAIT(SWAIT), .LIVES(LV)) dut (
      .clk(clk), .resetn(resetn), .start(start), .ball_y(ball_y),
      .hit_valid(hit_valid), .hit_brick(hit_brick), .brick_status(brick_status),
      .ball_en(ball_en), .ball_load(ball_load), .brick_clr(brick_clr),
      .brick_init(brick_init), .lives(lives), .score(score), .state(state),
      .game_over(game_over), .game_won(game_won)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   state_t m_state = ST_IDLE;
   int     m_lives = LV;
   int     m_score = 0;
   int     m_serve_ticks = 0;
   int     m_cyc = 0;        // clock edges since reset released
   logic   m_prev = 1'b0;
   logic   m_seen_low = 1'b0; // start observed low since reset

   logic        e_tick, e_req, e_hit;
   logic [11:0] e_clr, e_sh;
   always_comb begin
      e_tick = resetn && ((m_cyc % TD) == TD - 1);
      e_req  = resetn && start && !m_prev && m_seen_low;
      e_sh   = brick_status >> hit_brick;
      e_hit  = resetn && (m_state == ST_PLAY) && hit_valid && (hit_brick < 4'd12) && e_sh[0];
      e_clr  = e_hit ? (12'h001 << hit_brick) : 12'h000;
   end

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_state <= ST_IDLE; m_lives <= LV; m_score <= 0; m_serve_ticks <= 0;
         m_cyc <= 0; m_prev <= 1'b0; m_seen_low <= 1'b0;
      end else begin
         case (m_state)
            ST_IDLE, ST_WIN, ST_OVER:
               if (e_req) begin
                  m_state <= ST_SERVE; m_lives <= LV; m_score <= 0;
                  m_serve_ticks <= 0; bricks <= 12'hFFF;
               end
            ST_SERVE:
               if (e_tick) begin
                  m_serve_ticks <= m_serve_ticks + 1;
                  if (m_serve_ticks + 1 >= SWAIT) m_state <= ST_PLAY;
               end
            ST_PLAY: begin
               if (e_hit) begin
                  bricks  <= bricks & ~e_clr;
                  m_score <= (m_score < 255) ? m_score + 1 : 255;
               end
               if (brick_status == 12'h000)      m_state <= ST_WIN;
               else if (e_tick && ball_y == 10'd0) m_state <= ST_MISS;
            end
            ST_MISS: begin
               m_lives <= m_lives - 1;
               m_state <= (m_lives == 1) ? ST_OVER : ST_SERVE;
               m_serve_ticks <= 0;
            end
            default: m_state <= ST_IDLE;
         endcase
         if (!start) m_seen_low <= 1'b1;
         m_prev <= start;
         m_cyc  <= m_cyc + 1;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (brick_init) n_init++;
      chk("state", state, m_state);
      chk("lives", lives, m_lives);
      chk("score", score, m_score);
      chk("ball_en", ball_en, e_tick && m_state == ST_PLAY);
      chk("ball_load", ball_load, m_state == ST_SERVE);
      chk("brick_clr", brick_clr, e_clr);
      chk("brick_init", brick_init,
          e_req && (m_state == ST_IDLE || m_state == ST_WIN || m_state == ST_OVER));
      chk("game_over", game_over, m_state == ST_OVER);
      chk("game_won", game_won, m_state == ST_WIN);
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_pulse();
      start = 1'b1; step();
      start = 1'b0; step();
   endtask

   task automatic wait_state(input string nm, input logic [2:0] s, input int budget);
      for (int i = 0; i < budget && state != s; i++) step();
      chk(nm, state, s);
   endtask

   int cnt, init0;

   initial begin
      #2 resetn = 1'b0;
      #1;
      chk("rst_state", state, 0);
      chk("rst_lives", lives, 3);
      chk("rst_score", score, 0);
      chk("rst_outs", {ball_en, ball_load, brick_init, game_over, game_won}, 0);
      chk("rst_clr", brick_clr, 0);
      step(3);
      resetn = 1'b1;
      step(2);

      // first game: one start edge, serve, then periodic ball moves
      init0 = n_init;
      start_pulse();
      chk("init_once", n_init - init0, 1);
      chk("serve_state", state, 1);
      wait_state("to_play", ST_PLAY, 20);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin step(); cnt += ball_en; end
      chk("ball_en_rate", cnt, 4);

      // hit brick 5, then the same hit once it's gone
      hit_valid = 1'b1; hit_brick = 4'd5;
      @(negedge clk);
      chk("hit_clr", brick_clr, 12'h020);
      step();
      chk("hit_score", score, 1);
      chk("rehit_clr", brick_clr, 12'h000);
      step();
      chk("rehit_score", score, 1);
      hit_valid = 1'b0; hit_brick = NO_BRICK;

      // hit and miss landing on the same tick
      for (int i = 0; i < 8 && (m_cyc % TD) != TD - 1; i++) step();
      hit_valid = 1'b1; hit_brick = 4'd7; ball_y = 10'd0;
      step();
      hit_valid = 1'b0; hit_brick = NO_BRICK; ball_y = 10'd100;
      chk("hm_state", state, 3);
      chk("hm_score", score, 2);
      step();
      chk("hm_lives", lives, 2);
      chk("hm_serve", state, 1);

      // finish this game by missing out, then a fresh game lost 3->0
      ball_y = 10'd0;
      wait_state("over1", ST_OVER, 200);
      ball_y = 10'd100;
      start_pulse();
      chk("new_lives", lives, 3);
      ball_y = 10'd0;
      for (int k = 2; k >= 0; k--) begin
         wait_state("miss_wait", ST_MISS, 60);
         step();
         chk("miss_lives", lives, k);
      end
      chk("over_state", state, 5);
      chk("game_over", game_over, 1);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin step(); cnt += ball_en; end
      chk("over_no_ball", cnt, 0);
      ball_y = 10'd100;

      // win on an empty wall, then restart from WIN
      start_pulse();
      wait_state("win_play", ST_PLAY, 20);
      hit_valid = 1'b1; hit_brick = 4'd0; step(); hit_valid = 1'b0;
      force_empty = 1'b1;
      step();
      chk("win_state", state, 4);
      chk("game_won", game_won, 1);
      force_empty = 1'b0;
      start = 1'b1; step();
      chk("rewin_lives", lives, 3);
      chk("rewin_score", score, 0);
      chk("rewin_state", state, 1);
      start = 1'b0; step();

      // reset in PLAY with start held high
      wait_state("rst_play", ST_PLAY, 20);
      start = 1'b1; step(3);
      resetn = 1'b0; #2;
      chk("rst_mid_state", state, 0);
      chk("rst_mid_pulses", {brick_clr, brick_init}, 0);
      step(2);
      resetn = 1'b1;
      step(10);
      chk("held_start_idle", state, 0);
      start = 1'b0; step();
      start = 1'b1; step();
      chk("restart_serve", state, 1);
      start = 1'b0;

      // random play
      for (int i = 0; i < 3000; i++) begin
         hit_valid   = ($urandom % 3) == 0;
         hit_brick   = 4'($urandom % 16);
         ball_y      = (($urandom % 8) == 0) ? 10'd0 : 10'($urandom);
         if (($urandom % 12) == 0) start = ~start;
         force_empty = ($urandom % 150) == 0;
         resetn      = ($urandom % 400) != 0;
         step();
      end
      resetn = 1'b1; force_empty = 1'b0;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
